// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO subsystem controller: state encoding and
// the default thresholds of the standard configuration.
package fifo_ctrl_pkg;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    typedef enum logic [2:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_e;

    localparam int DEF_AE_STD = 1;
    localparam int DEF_AF_STD = 7;

endpackage

// File: rtl/fifo_ctrl_fsm_param_empty_hold.sv
// Counts consecutive all-empty cycles; done flags the edge on which the
// count would reach IDLE_HOLD, and the count restarts from zero there.
module empty_hold_cnt #(
    parameter int IDLE_HOLD = 2
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clear,
    input  logic all_empty,
    output logic done
);

    localparam int CW = $clog2(IDLE_HOLD + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign done = all_empty && (cnt_q == CW'(IDLE_HOLD - 1));

    // Clearing on done keeps the count strictly below IDLE_HOLD, so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !all_empty || done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_ctrl_fsm_param.sv
// FIFO subsystem controller: validates and broadcasts almost-empty/full
// thresholds and reports idle once every FIFO has stayed drained long enough.
module fifo_ctrl_fsm_param
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS = 9,
    parameter int TH_WIDTH  = 3,
    parameter int DEF_AE    = DEF_AE_STD,
    parameter int DEF_AF    = DEF_AF_STD,
    parameter int IDLE_HOLD = 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [NUM_FIFOS-1:0] fifos_empty,
    input  logic [TH_WIDTH-1:0]  th_almost_empty,
    input  logic [TH_WIDTH-1:0]  th_almost_full,
    output logic [TH_WIDTH-1:0]  th_fifos_almost_empty,
    output logic [TH_WIDTH-1:0]  th_fifos_almost_full,
    output logic                 idle,
    output logic                 error,
    output logic [2:0]           state
);

    state_e              state_q, state_d;
    logic [TH_WIDTH-1:0] ae_q, ae_d;
    logic [TH_WIDTH-1:0] af_q, af_d;
    logic                th_valid;
    logic                all_empty;
    logic                hold_clear;
    logic                hold_done;

    assign th_valid   = (th_almost_empty != '0) && (th_almost_empty < th_almost_full);
    assign all_empty  = &fifos_empty;
    // Counting only runs in ACTIVE without a pending init request.
    assign hold_clear = (state_q != S_ACTIVE) || init;

    empty_hold_cnt #(
        .IDLE_HOLD (IDLE_HOLD)
    ) u_hold (
        .clk       (clk),
        .reset_L   (reset_L),
        .clear     (hold_clear),
        .all_empty (all_empty),
        .done      (hold_done)
    );

    always_comb begin
        state_d = state_q;
        ae_d    = ae_q;
        af_d    = af_q;
        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT: begin
                if (th_valid) begin
                    ae_d    = th_almost_empty;
                    af_d    = th_almost_full;
                    state_d = init ? S_INIT : S_IDLE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_IDLE: begin
                if (init) begin
                    state_d = S_INIT;
                end else if (!all_empty) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (init) begin
                    state_d = S_INIT;
                end else if (hold_done) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (init && th_valid) begin
                    ae_d    = th_almost_empty;
                    af_d    = th_almost_full;
                    state_d = S_INIT;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= S_RESET;
            ae_q    <= TH_WIDTH'(DEF_AE);
            af_q    <= TH_WIDTH'(DEF_AF);
        end else begin
            state_q <= state_d;
            ae_q    <= ae_d;
            af_q    <= af_d;
        end
    end

    assign th_fifos_almost_empty = ae_q;
    assign th_fifos_almost_full  = af_q;
    assign state                 = state_q;
    assign idle                  = (state_q == S_IDLE);
    assign error                 = (state_q == S_ERROR);

endmodule
